uart_pkt_parse: RTL
===================

UART_PKT_PARSE -- requirements
Module: uart_pkt_parse

Interface
REQ-001 SHALL have parameter C_HEAD, default 8'hA5, frame header byte.
REQ-002 SHALL have parameter C_MAX_LEN, default 16, maximum payload bytes per frame (1..255).
REQ-003 SHALL have parameter C_TIMEOUT, default 100000, mid-frame inter-byte timeout in I_clk cycles (>=2).
REQ-004 SHALL have port I_clk  input  1  clock; all logic on its rising edge.
REQ-005 SHALL have port I_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port I_data  input  8  received byte from the UART receiver.
REQ-007 SHALL have port I_data_v  input  1  one-cycle strobe, I_data valid; no backpressure possible.
REQ-008 SHALL have port O_data  output  8  payload byte out.
REQ-009 SHALL have port O_data_v  output  1  payload byte valid.
REQ-010 SHALL have port I_rdy  input  1  downstream ready; transfer when O_data_v && I_rdy.
REQ-011 SHALL have port O_last  output  1  marks the final payload byte, qualified by O_data_v.
REQ-012 SHALL have port O_frame_ok  output  1  one-cycle pulse, frame passed all checks.
REQ-013 SHALL have port O_err  output  1  one-cycle pulse, frame aborted.
REQ-014 SHALL have port O_err_code  output  2  valid with O_err: 1 bad length, 2 checksum mismatch, 3 timeout; holds last code otherwise.
REQ-015 SHALL have port O_drop  output  1  one-cycle pulse, input byte discarded during output phase.
REQ-016 SHALL have port O_busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement frame format: C_HEAD, LEN, LEN payload bytes, CHK; CHK = (LEN + sum of payload) mod 256.
REQ-018 SHALL use states IDLE, LEN, PAY, CHK, OUT; all outputs registered.
REQ-019 IDLE: byte == C_HEAD -> LEN; any other byte ignored, no pulse.
REQ-020 LEN: LEN == 0 or LEN > C_MAX_LEN -> O_err=1, code 1, next cycle, -> IDLE; else store LEN, init checksum to LEN, -> PAY.
REQ-021 PAY: each byte written to internal buffer at index 0..LEN-1 and added to checksum; after LEN-th byte -> CHK.
REQ-022 SHALL treat a C_HEAD value inside LEN/PAY/CHK as ordinary data (no resync).
REQ-023 CHK: byte == checksum -> O_frame_ok=1 next cycle, -> OUT; else O_err=1, code 2, -> IDLE, buffer discarded.
REQ-024 OUT: O_data_v=1 and O_data=buffer[0] starting the cycle after the checksum byte (1-cycle latency).
REQ-025 O_data/O_last SHALL hold stable while O_data_v && !I_rdy; each transfer advances index; next byte presented the following cycle with no bubble.
REQ-026 O_last=1 with byte LEN-1; after its transfer O_data_v=0 next cycle, -> IDLE.
REQ-027 OUT has no timeout; waits indefinitely on I_rdy.
REQ-028 I_data_v in OUT: byte discarded, O_drop=1 next cycle; header not hunted until IDLE.
REQ-029 Timeout counter SHALL run in LEN/PAY/CHK, clear on every I_data_v and on state entry; at C_TIMEOUT-1 without a byte -> O_err=1, code 3, -> IDLE.
REQ-030 I_data_v in the same cycle the counter reaches terminal SHALL win: byte processed, no timeout.
REQ-031 Checksum arithmetic SHALL be 8-bit, overflow discarded.
REQ-032 O_frame_ok, O_err, O_drop SHALL never be high for more than one consecutive cycle per event.

Reset
REQ-033 I_rst SHALL force IDLE, O_data_v=0, O_last=0, O_frame_ok=0, O_err=0, O_err_code=0, O_drop=0, O_busy=0, O_data=0, counters 0 on next edge, from any state including mid-OUT.
REQ-034 Buffer contents SHALL NOT require reset.
REQ-035 I_rst SHALL take priority over I_data_v and I_rdy in the same cycle.

Verification
REQ-036 Bytes A5,03,10,20,30,63 with I_rdy=1 -> O_frame_ok pulse; O_data 10,20,30 on three consecutive cycles, O_last with 30; O_busy low after.
REQ-037 Bytes A5,02,01,02,00 -> O_err=1, code 2; no O_data_v.
REQ-038 Bytes A5,00 and A5,11 (C_MAX_LEN=16) -> O_err code 1 after each length byte; A5,10 accepted.
REQ-039 A5,02,01 then idle C_TIMEOUT cycles -> O_err code 3; following A5,01,7F,80 parses OK with O_data 7F.
REQ-040 Valid 2-byte frame, I_rdy toggled 0/1 randomly, extra byte injected in OUT -> data stable while stalled, O_drop pulse, both bytes delivered in order.
REQ-041 I_rst asserted mid-PAY and mid-OUT -> all outputs at reset values next cycle; next valid frame parses correctly.

Source files
------------

// File: rtl/uart_pkt_parse_if.sv
// Byte-stream bus between a UART receiver, the packet parser and its downstream consumer.
// The parser sits on the slave side; the driver/consumer side uses master.
interface uart_pkt_parse_if;
    logic       I_data_v;
    logic [7:0] I_data;
    logic [7:0] O_data;
    logic       O_data_v;
    logic       I_rdy;
    logic       O_last;
    logic       O_frame_ok;
    logic       O_err;
    logic [1:0] O_err_code;
    logic       O_drop;
    logic       O_busy;

    modport slave (
        input  I_data, I_data_v, I_rdy,
        output O_data, O_data_v, O_last, O_frame_ok, O_err, O_err_code, O_drop, O_busy
    );

    modport master (
        output I_data, I_data_v, I_rdy,
        input  O_data, O_data_v, O_last, O_frame_ok, O_err, O_err_code, O_drop, O_busy
    );
endinterface

// File: rtl/uart_pkt_parse.sv
// Frame parser for HEAD, LEN, payload, CHK byte streams.
// Buffers a checked frame and replays it over a ready/valid output.
module uart_pkt_parse #(
    parameter logic [7:0] C_HEAD    = 8'hA5,
    parameter int         C_MAX_LEN = 16,
    parameter int         C_TIMEOUT = 100000
) (
    input  logic           I_clk,
    input  logic           I_rst,
    uart_pkt_parse_if.slave bus
);
    localparam int               IDX_W     = (C_MAX_LEN > 1) ? $clog2(C_MAX_LEN) : 1;
    localparam int               CNT_W     = $clog2(C_TIMEOUT);
    localparam logic [7:0]       MAX_LEN_B = 8'(C_MAX_LEN);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(C_TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAY, S_CHK, S_OUT} state_t;

    state_t           state_q, state_n;
    logic [7:0]       len_q, len_n;
    logic [7:0]       idx_q, idx_n;
    logic [7:0]       sum_q, sum_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [7:0]       data_q, data_n;
    logic             data_v_q, data_v_n;
    logic             last_q, last_n;
    logic             ok_q, ok_n;
    logic             err_q, err_n;
    logic [1:0]       code_q, code_n;
    logic             drop_q, drop_n;
    logic             busy_q, busy_n;
    logic             buf_we;
    logic [IDX_W-1:0] buf_wa;
    logic [7:0]       idx_nxt;
    logic [7:0]       pay_mem [2**IDX_W];

    function automatic logic [7:0] sum_add(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            idx_q    <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            data_v_q <= 1'b0;
            last_q   <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= '0;
            drop_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            len_q    <= len_n;
            idx_q    <= idx_n;
            sum_q    <= sum_n;
            cnt_q    <= cnt_n;
            data_q   <= data_n;
            data_v_q <= data_v_n;
            last_q   <= last_n;
            ok_q     <= ok_n;
            err_q    <= err_n;
            code_q   <= code_n;
            drop_q   <= drop_n;
            busy_q   <= busy_n;
        end
    end

    // Payload storage carries no reset; only the control path needs a known state.
    always_ff @(posedge I_clk) begin
        if (buf_we) pay_mem[buf_wa] <= bus.I_data;
    end

    always_comb begin
        state_n  = state_q;
        len_n    = len_q;
        idx_n    = idx_q;
        sum_n    = sum_q;
        cnt_n    = cnt_q;
        data_n   = data_q;
        data_v_n = data_v_q;
        last_n   = last_q;
        ok_n     = 1'b0;
        err_n    = 1'b0;
        code_n   = code_q;
        drop_n   = 1'b0;
        buf_we   = 1'b0;
        buf_wa   = idx_q[IDX_W-1:0];
        idx_nxt  = idx_q + 8'd1;

        case (state_q)
            S_IDLE: begin
                if (bus.I_data_v && bus.I_data == C_HEAD) begin
                    state_n = S_LEN;
                    cnt_n   = '0;
                end
            end
            S_LEN: begin
                if (bus.I_data_v) begin
                    cnt_n = '0;
                    if (bus.I_data == 8'd0 || bus.I_data > MAX_LEN_B) begin
                        err_n   = 1'b1;
                        code_n  = 2'd1;
                        state_n = S_IDLE;
                    end else begin
                        len_n   = bus.I_data;
                        sum_n   = bus.I_data;
                        idx_n   = '0;
                        state_n = S_PAY;
                    end
                end
            end
            S_PAY: begin
                if (bus.I_data_v) begin
                    cnt_n  = '0;
                    buf_we = 1'b1;
                    sum_n  = sum_add(sum_q, bus.I_data);
                    if (idx_q == len_q - 8'd1) begin
                        idx_n   = '0;
                        state_n = S_CHK;
                    end else begin
                        idx_n = idx_nxt;
                    end
                end
            end
            S_CHK: begin
                if (bus.I_data_v) begin
                    cnt_n = '0;
                    if (bus.I_data == sum_q) begin
                        ok_n     = 1'b1;
                        state_n  = S_OUT;
                        idx_n    = '0;
                        data_v_n = 1'b1;
                        data_n   = pay_mem[0];
                        last_n   = (len_q == 8'd1);
                    end else begin
                        err_n   = 1'b1;
                        code_n  = 2'd2;
                        state_n = S_IDLE;
                    end
                end
            end
            S_OUT: begin
                drop_n = bus.I_data_v;
                if (bus.I_rdy) begin
                    if (last_q) begin
                        data_v_n = 1'b0;
                        last_n   = 1'b0;
                        state_n  = S_IDLE;
                    end else begin
                        idx_n  = idx_nxt;
                        data_n = pay_mem[idx_nxt[IDX_W-1:0]];
                        last_n = (idx_nxt == len_q - 8'd1);
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        // A byte arriving on the terminal count is handled above and wins over the timeout.
        if ((state_q == S_LEN || state_q == S_PAY || state_q == S_CHK) && !bus.I_data_v) begin
            if (cnt_q == TMO_LAST) begin
                err_n   = 1'b1;
                code_n  = 2'd3;
                cnt_n   = '0;
                state_n = S_IDLE;
            end else begin
                cnt_n = cnt_q + 1'b1;
            end
        end

        busy_n = (state_n != S_IDLE);
    end

    assign bus.O_data     = data_q;
    assign bus.O_data_v   = data_v_q;
    assign bus.O_last     = last_q;
    assign bus.O_frame_ok = ok_q;
    assign bus.O_err      = err_q;
    assign bus.O_err_code = code_q;
    assign bus.O_drop     = drop_q;
    assign bus.O_busy     = busy_q;
endmodule
